mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter in front of a single-ported memory. The instruction
//   cache (ic_*) and the load/store buffer (lsb_*) each own a one-entry
//   pending slot. When idle, the FSM grants one eligible requester. On a tie
//   it picks the one that was not granted last. It issues a one-cycle
//   mem_req, holds the command fields until mem_ready, and then routes the
//   read data back.
//
// Ports
//   clk, rst                         rising-edge clock, synchronous active-high reset
//   ic_asking, ic_addr, ic_flush     fetch request pulse, fetch address, pipeline flush
//   lsb_req, lsb_we, lsb_addr,       load/store request pulse and command
//   lsb_wdata, lsb_wmask
//   mem_rdata, mem_ready             memory read data and completion pulse
//   mem_req, mem_we, mem_addr,       memory request pulse and command fields
//   mem_wdata, mem_wmask
//   ic_data, ic_data_ready           returned instruction word and its valid pulse
//   lsb_rdata, lsb_done              returned load data and completion pulse
//   ic_busy, lsb_busy                requester has a pending or in-flight access
//   dbg_state                        current FSM state (IDLE=0, BUSY_IC=1, BUSY_LSB=2)
//
// Handshake: every *_asking/*_req/mem_ready/*_ready/*_done signal is a
// single-cycle pulse sampled on the rising edge of clk. There is no
// back-pressure. A request pulse that arrives while its requester is busy
// is dropped. The memory command fields are stable from the mem_req cycle
// until the edge where mem_ready is sampled.

module mem_arbiter #(
    parameter logic INIT_PRIO = 1'b1   // 1: LSB wins the first tie, 0: IC wins
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_asking,
    input  logic [31:0] ic_addr,
    input  logic        ic_flush,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic [3:0]  lsb_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [31:0] ic_data,
    output logic        ic_data_ready,
    output logic [31:0] lsb_rdata,
    output logic        lsb_done,
    output logic        ic_busy,
    output logic        lsb_busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IC  = 2'd1,
        BUSY_LSB = 2'd2
    } state_t;

    state_t      state;

    // Pending slots
    logic        ic_pend;
    logic [31:0] ic_pend_addr;
    logic        lsb_pend;
    logic        lsb_pend_we;
    logic [31:0] lsb_pend_addr;
    logic [31:0] lsb_pend_wdata;
    logic [3:0]  lsb_pend_wmask;

    logic        last_ic;   // 1: IC holds the most recent grant
    logic        discard;   // in-flight fetch was flushed; swallow its data

    // Next-cycle decisions
    logic        ic_busy_cur, lsb_busy_cur;
    logic        take_ic, take_lsb;
    logic        ic_cand, lsb_cand;
    logic [31:0] ic_cand_addr;
    logic        lsb_cand_we;
    logic [31:0] lsb_cand_addr, lsb_cand_wdata;
    logic [3:0]  lsb_cand_wmask;
    logic        grant_ic, grant_lsb;
    logic        ic_pend_next, lsb_pend_next;
    logic        ic_busy_next, lsb_busy_next;

    always_comb begin
        ic_busy_cur  = ic_pend  | (state == BUSY_IC);
        lsb_busy_cur = lsb_pend | (state == BUSY_LSB);

        // A flush frees the IC slot in the same cycle. This lets a
        // simultaneous fetch be accepted even while the old fetch is still
        // in flight.
        take_ic      = ic_asking & (ic_flush | ~ic_busy_cur);
        ic_cand      = take_ic | (ic_pend & ~ic_flush);
        ic_cand_addr = take_ic ? ic_addr : ic_pend_addr;

        take_lsb       = lsb_req & ~lsb_busy_cur;
        lsb_cand       = take_lsb | lsb_pend;
        lsb_cand_we    = take_lsb ? lsb_we    : lsb_pend_we;
        lsb_cand_addr  = take_lsb ? lsb_addr  : lsb_pend_addr;
        lsb_cand_wdata = take_lsb ? lsb_wdata : lsb_pend_wdata;
        lsb_cand_wmask = take_lsb ? lsb_wmask : lsb_pend_wmask;

        // On a tie, the side that was not granted last wins.
        grant_ic  = (state == IDLE) & ic_cand & (~lsb_cand | ~last_ic);
        grant_lsb = (state == IDLE) & lsb_cand & ~grant_ic;

        ic_pend_next  = ic_cand  & ~grant_ic;
        lsb_pend_next = lsb_cand & ~grant_lsb;

        ic_busy_next  = ic_pend_next  | grant_ic  | ((state == BUSY_IC)  & ~mem_ready);
        lsb_busy_next = lsb_pend_next | grant_lsb | ((state == BUSY_LSB) & ~mem_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ic_pend        <= 1'b0;
            ic_pend_addr   <= '0;
            lsb_pend       <= 1'b0;
            lsb_pend_we    <= 1'b0;
            lsb_pend_addr  <= '0;
            lsb_pend_wdata <= '0;
            lsb_pend_wmask <= '0;
            last_ic        <= INIT_PRIO;
            discard        <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ic_data        <= '0;
            ic_data_ready  <= 1'b0;
            lsb_rdata      <= '0;
            lsb_done       <= 1'b0;
            ic_busy        <= 1'b0;
            lsb_busy       <= 1'b0;
        end else begin
            ic_pend  <= ic_pend_next;
            lsb_pend <= lsb_pend_next;
            if (take_ic) begin
                ic_pend_addr <= ic_addr;
            end
            if (take_lsb) begin
                lsb_pend_we    <= lsb_we;
                lsb_pend_addr  <= lsb_addr;
                lsb_pend_wdata <= lsb_wdata;
                lsb_pend_wmask <= lsb_wmask;
            end
            ic_busy       <= ic_busy_next;
            lsb_busy      <= lsb_busy_next;
            mem_req       <= 1'b0;
            ic_data_ready <= 1'b0;
            lsb_done      <= 1'b0;

            case (state)
                IDLE: begin
                    // mem_ready while idle is stale or spurious and is ignored.
                    if (grant_ic) begin
                        state     <= BUSY_IC;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ic_cand_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        last_ic   <= 1'b1;
                    end else if (grant_lsb) begin
                        state     <= BUSY_LSB;
                        mem_req   <= 1'b1;
                        mem_we    <= lsb_cand_we;
                        mem_addr  <= lsb_cand_addr;
                        mem_wdata <= lsb_cand_wdata;
                        mem_wmask <= lsb_cand_wmask;
                        last_ic   <= 1'b0;
                    end
                end
                BUSY_IC: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                        // A flush on the completing edge also cancels delivery.
                        if (!(discard || ic_flush)) begin
                            ic_data       <= mem_rdata;
                            ic_data_ready <= 1'b1;
                        end
                    end else if (ic_flush) begin
                        discard <= 1'b1;
                    end
                end
                BUSY_LSB: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        lsb_rdata <= mem_rdata;
                        lsb_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_asking, ic_flush;
  logic [31:0] ic_addr;
  logic        lsb_req, lsb_we;
  logic [31:0] lsb_addr, lsb_wdata;
  logic [3:0]  lsb_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] ic_data, lsb_rdata;
  logic        ic_data_ready, lsb_done, ic_busy, lsb_busy;
  logic [1:0]  dbg_state;
  logic [137:0] all_out;

  mem_arbiter #(.INIT_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ic_asking(ic_asking), .ic_addr(ic_addr), .ic_flush(ic_flush),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_wmask(lsb_wmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .ic_data(ic_data), .ic_data_ready(ic_data_ready),
    .lsb_rdata(lsb_rdata), .lsb_done(lsb_done),
    .ic_busy(ic_busy), .lsb_busy(lsb_busy), .dbg_state(dbg_state)
  );

  assign all_out = {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ic_data,
                    ic_data_ready, lsb_rdata, lsb_done, ic_busy, lsb_busy};

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder
  bit          auto_mem = 0;
  bit          spurious_en = 0;
  int          lat_lo = 1, lat_hi = 1;
  int          resp_mode = 0;            // 0 fixed, 1 address-derived, 2 random
  logic [31:0] resp_fixed = '0;
  bit          resp_pend = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = '0;
  localparam logic [31:0] ADDR_KEY = 32'h5A5A_0000;

  // pulse counters
  int n_mem_req, n_ic_rdy, n_lsb_done;

  // reference model: requester wait flags, current owner of memory
  bit          m_ic_wait, m_l_wait, m_discard, m_last_ic;
  int          m_owner;                  // 0 none, 1 IC, 2 LSB
  logic [31:0] m_ic_addr, m_l_addr, m_l_wdata;
  logic        m_l_we;
  logic [3:0]  m_l_wmask;
  logic        e_mem_req, e_mem_we, e_ic_rdy, e_lsb_done, e_ic_busy, e_lsb_busy;
  logic [31:0] e_mem_addr, e_mem_wdata, e_ic_data, e_lsb_rdata;
  logic [3:0]  e_mem_wmask;

  task automatic model_reset();
    m_ic_wait = 0; m_l_wait = 0; m_discard = 0; m_owner = 0;
    m_last_ic = 1;                        // INIT_PRIO=1: LSB wins the first tie
    m_ic_addr = '0; m_l_addr = '0; m_l_wdata = '0; m_l_we = 0; m_l_wmask = '0;
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_wmask = '0;
    e_ic_rdy = 0; e_ic_data = '0; e_lsb_done = 0; e_lsb_rdata = '0;
    e_ic_busy = 0; e_lsb_busy = 0;
  endtask

  task automatic model_edge();
    bit ic_was, l_was;
    e_mem_req = 0; e_ic_rdy = 0; e_lsb_done = 0;
    if (rst) begin
      model_reset();
      return;
    end
    ic_was = m_ic_wait || (m_owner == 1);
    l_was  = m_l_wait  || (m_owner == 2);
    if (ic_flush) begin
      m_ic_wait = 0;
      if (m_owner == 1) m_discard = 1;
    end
    if (ic_asking && (ic_flush || !ic_was)) begin
      m_ic_wait = 1; m_ic_addr = ic_addr;
    end
    if (lsb_req && !l_was) begin
      m_l_wait = 1; m_l_we = lsb_we; m_l_addr = lsb_addr;
      m_l_wdata = lsb_wdata; m_l_wmask = lsb_wmask;
    end
    if (m_owner == 1) begin
      if (mem_ready) begin
        if (!m_discard) begin e_ic_rdy = 1; e_ic_data = mem_rdata; end
        m_discard = 0; m_owner = 0;
      end
    end else if (m_owner == 2) begin
      if (mem_ready) begin
        e_lsb_done = 1; e_lsb_rdata = mem_rdata; m_owner = 0;
      end
    end else begin
      if (m_ic_wait && (!m_l_wait || !m_last_ic)) begin
        m_owner = 1; m_ic_wait = 0; m_last_ic = 1; e_mem_req = 1;
        e_mem_addr = m_ic_addr; e_mem_we = 0; e_mem_wdata = '0; e_mem_wmask = '0;
      end else if (m_l_wait) begin
        m_owner = 2; m_l_wait = 0; m_last_ic = 0; e_mem_req = 1;
        e_mem_addr = m_l_addr; e_mem_we = m_l_we; e_mem_wdata = m_l_wdata;
        e_mem_wmask = m_l_wmask;
      end
    end
    e_ic_busy  = m_ic_wait || (m_owner == 1);
    e_lsb_busy = m_l_wait  || (m_owner == 2);
  endtask

  // driver: one clock edge; inputs set by the caller are sampled at it
  task automatic tick();
    if (auto_mem) begin
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          mem_ready = 1; mem_rdata = resp_data; resp_pend = 0;
        end else begin
          resp_cnt--;
        end
      end else if (spurious_en && m_owner == 0 && $urandom_range(0, 7) == 0) begin
        mem_ready = 1; mem_rdata = $urandom;
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    if (mem_req) n_mem_req++;
    if (ic_data_ready) n_ic_rdy++;
    if (lsb_done) n_lsb_done++;
    if (auto_mem && mem_req) begin
      resp_pend = 1;
      resp_cnt  = $urandom_range(lat_lo, lat_hi);
      case (resp_mode)
        0: resp_data = resp_fixed;
        1: resp_data = mem_addr ^ ADDR_KEY;
        default: resp_data = $urandom;
      endcase
    end
    ic_asking = 0; ic_flush = 0; lsb_req = 0; mem_ready = 0;
  endtask

  task automatic apply_reset();
    rst = 1; tick(); tick(); rst = 0;
    resp_pend = 0;
    n_mem_req = 0; n_ic_rdy = 0; n_lsb_done = 0;
  endtask

  task automatic test_reset();
    ic_asking = 1; lsb_req = 1; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    apply_reset();
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", dbg_state);
    end
  endtask

  task automatic test_single_fetch();
    logic [31:0] seen_data;
    int rdy_idx;
    apply_reset();
    auto_mem = 1; lat_lo = 3; lat_hi = 3; resp_mode = 0; resp_fixed = 32'h0000_0013;
    ic_asking = 1; ic_addr = 32'h100;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_grant got req=%b addr=%h we=%b exp 1/100/0", mem_req, mem_addr, mem_we);
    end
    checks++;
    if (ic_busy !== 1'b1) begin
      errors++; $display("FAIL fetch_busy got %b exp 1", ic_busy);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_hold got req=%b addr=%h exp 0/100", mem_req, mem_addr);
    end
    rdy_idx = -1; seen_data = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ic_data_ready) begin rdy_idx = i; seen_data = ic_data; end
    end
    // mem_req in cycle C, mem_ready in C+3, ic_data_ready in C+4
    checks++;
    if (rdy_idx !== 2 || seen_data !== 32'h0000_0013) begin
      errors++; $display("FAIL fetch_return got idx=%0d data=%h exp 2/00000013", rdy_idx, seen_data);
    end
    checks++;
    if (n_mem_req !== 1 || n_ic_rdy !== 1) begin
      errors++; $display("FAIL fetch_pulses got req=%0d rdy=%0d exp 1/1", n_mem_req, n_ic_rdy);
    end
  endtask

  task automatic test_tie_init_prio();
    int lsb_i, ic_i, done_i, rdy_i;
    logic [31:0] ic_a; logic ic_we; logic [3:0] ic_m;
    apply_reset();
    auto_mem = 1; lat_lo = 2; lat_hi = 2; resp_mode = 0; resp_fixed = 32'h1234_5678;
    ic_asking = 1; ic_addr = 32'h104;
    lsb_req = 1; lsb_we = 1; lsb_addr = 32'h2000; lsb_wdata = 32'hDEAD_BEEF; lsb_wmask = 4'hF;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
      errors++; $display("FAIL tie_lsb_first got req=%b we=%b addr=%h wdata=%h mask=%h exp 1/1/2000/deadbeef/f",
                         mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
    end
    checks++;
    if (ic_busy !== 1'b1 || lsb_busy !== 1'b1) begin
      errors++; $display("FAIL tie_busy got ic=%b lsb=%b exp 1/1", ic_busy, lsb_busy);
    end
    lsb_i = -1; ic_i = -1; done_i = -1; rdy_i = -1; ic_a = '0; ic_we = 1; ic_m = 4'hF;
    for (int i = 1; i < 12; i++) begin
      tick();
      if (mem_req && mem_we) lsb_i = i;
      if (mem_req && !mem_we) begin ic_i = i; ic_a = mem_addr; ic_we = mem_we; ic_m = mem_wmask; end
      if (lsb_done) done_i = i;
      if (ic_data_ready) rdy_i = i;
    end
    checks++;
    if (done_i !== 3 || lsb_i !== -1) begin
      errors++; $display("FAIL tie_lsb_done got idx=%0d extra_lsb=%0d exp 3/-1", done_i, lsb_i);
    end
    checks++;
    if (ic_i !== 4 || ic_a !== 32'h104 || ic_we !== 1'b0 || ic_m !== 4'h0) begin
      errors++; $display("FAIL tie_ic_second got idx=%0d addr=%h we=%b mask=%h exp 4/104/0/0", ic_i, ic_a, ic_we, ic_m);
    end
    checks++;
    if (rdy_i !== 7) begin
      errors++; $display("FAIL tie_ic_return got idx=%0d exp 7", rdy_i);
    end
  endtask

  task automatic test_back_to_back();
    int grants, bad, prev_side, side, k;
    apply_reset();
    auto_mem = 1; lat_lo = 1; lat_hi = 3; resp_mode = 2;
    grants = 0; bad = 0; prev_side = -1; k = 0;
    for (int i = 0; i < 300; i++) begin
      if (!ic_busy) begin ic_asking = 1; ic_addr = 32'h1000 + 32'(k * 4); end
      if (!lsb_busy) begin
        lsb_req = 1; lsb_we = 0; lsb_addr = 32'h8000 + 32'(k * 4);
        lsb_wdata = $urandom; lsb_wmask = 4'(($urandom_range(0, 15)));
      end
      k++;
      tick();
      if (mem_req) begin
        side = mem_addr[15] ? 2 : 1;
        if (side == prev_side) bad++;
        prev_side = side;
        grants++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b_alternate got %0d repeats exp 0", bad);
    end
    checks++;
    if (grants < 40) begin
      errors++; $display("FAIL b2b_grants got %0d exp >= 40", grants);
    end
  endtask

  task automatic test_flush();
    int rdy_cnt, req_idx, req_cnt, gap;
    logic [31:0] got_data, req_addr;
    bit seen_rdy;
    apply_reset();
    auto_mem = 1; lat_lo = 4; lat_hi = 4; resp_mode = 1;
    ic_asking = 1; ic_addr = 32'h40;
    tick();
    tick();
    ic_flush = 1; ic_asking = 1; ic_addr = 32'h80;
    tick();
    checks++;
    if (ic_busy !== 1'b1) begin
      errors++; $display("FAIL flush_busy got %b exp 1", ic_busy);
    end
    rdy_cnt = 0; req_idx = -1; req_cnt = 0; gap = 0; seen_rdy = 0;
    got_data = '0; req_addr = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req) begin req_cnt++; req_idx = i; req_addr = mem_addr; end
      if (ic_data_ready) begin rdy_cnt++; got_data = ic_data; seen_rdy = 1; end
      if (!seen_rdy && !ic_busy) gap++;
    end
    checks++;
    if (rdy_cnt !== 1 || got_data !== (32'h80 ^ ADDR_KEY)) begin
      errors++; $display("FAIL flush_return got cnt=%0d data=%h exp 1/%h", rdy_cnt, got_data, 32'h80 ^ ADDR_KEY);
    end
    checks++;
    if (req_cnt !== 1 || req_idx !== 3 || req_addr !== 32'h80) begin
      errors++; $display("FAIL flush_reissue got cnt=%0d idx=%0d addr=%h exp 1/3/80", req_cnt, req_idx, req_addr);
    end
    checks++;
    if (gap !== 0) begin
      errors++; $display("FAIL flush_busy_gap got %0d exp 0", gap);
    end
  endtask

  task automatic test_drop_repeat();
    apply_reset();
    auto_mem = 1; lat_lo = 3; lat_hi = 3; resp_mode = 0; resp_fixed = 32'h1122_3344;
    ic_asking = 1; ic_addr = 32'h200;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (ic_busy) begin ic_asking = 1; ic_addr = 32'h300 + 32'(i * 4); end
      tick();
    end
    checks++;
    if (n_mem_req !== 1 || n_ic_rdy !== 1) begin
      errors++; $display("FAIL drop_count got req=%0d rdy=%0d exp 1/1", n_mem_req, n_ic_rdy);
    end
    checks++;
    if (mem_addr !== 32'h200 || ic_data !== 32'h1122_3344) begin
      errors++; $display("FAIL drop_addr got addr=%h data=%h exp 200/11223344", mem_addr, ic_data);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    auto_mem = 0;
    lsb_req = 1; lsb_we = 0; lsb_addr = 32'h3000;
    tick();
    checks++;
    if (mem_req !== 1'b1 || lsb_busy !== 1'b1) begin
      errors++; $display("FAIL rmid_grant got req=%b busy=%b exp 1/1", mem_req, lsb_busy);
    end
    tick();
    rst = 1; lsb_req = 1; ic_asking = 1; ic_addr = 32'h500;
    tick();
    rst = 0;
    n_lsb_done = 0; n_mem_req = 0;
    mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    checks++;
    if (all_out !== '0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rmid_outputs got %h state=%0d exp 0/0", all_out, dbg_state);
    end
    tick(); tick();
    checks++;
    if (n_lsb_done !== 0 || n_mem_req !== 0 || all_out !== '0) begin
      errors++; $display("FAIL rmid_stale got done=%0d req=%0d out=%h exp 0/0/0", n_lsb_done, n_mem_req, all_out);
    end
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    auto_mem = 1; spurious_en = 1; lat_lo = 1; lat_hi = 4; resp_mode = 2;
    bad = 0;
    for (int c = 0; c < 2500; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      ic_asking = ($urandom_range(0, 2) == 0);
      ic_addr   = $urandom & 32'hFFFF_FFFC;
      ic_flush  = ($urandom_range(0, 11) == 0);
      lsb_req   = ($urandom_range(0, 2) == 0);
      lsb_we    = $urandom_range(0, 1);
      lsb_addr  = $urandom;
      lsb_wdata = $urandom;
      lsb_wmask = 4'($urandom_range(0, 15));
      tick();
      rst = 0;
      checks++;
      if (mem_req !== e_mem_req || ic_data_ready !== e_ic_rdy || lsb_done !== e_lsb_done) begin
        errors++; bad++;
        $display("FAIL rnd_pulses cyc %0d got req=%b rdy=%b done=%b exp %b/%b/%b",
                 c, mem_req, ic_data_ready, lsb_done, e_mem_req, e_ic_rdy, e_lsb_done);
      end
      checks++;
      if (ic_busy !== e_ic_busy || lsb_busy !== e_lsb_busy) begin
        errors++; bad++;
        $display("FAIL rnd_busy cyc %0d got ic=%b lsb=%b exp %b/%b", c, ic_busy, lsb_busy, e_ic_busy, e_lsb_busy);
      end
      if (m_owner != 0) begin
        checks++;
        if (mem_addr !== e_mem_addr || mem_we !== e_mem_we || mem_wmask !== e_mem_wmask ||
            (m_owner == 2 && mem_wdata !== e_mem_wdata)) begin
          errors++; bad++;
          $display("FAIL rnd_cmd cyc %0d got addr=%h we=%b mask=%h wdata=%h exp %h/%b/%h/%h",
                   c, mem_addr, mem_we, mem_wmask, mem_wdata, e_mem_addr, e_mem_we, e_mem_wmask, e_mem_wdata);
        end
      end
      if (e_ic_rdy) begin
        checks++;
        if (ic_data !== e_ic_data) begin
          errors++; bad++; $display("FAIL rnd_ic_data cyc %0d got %h exp %h", c, ic_data, e_ic_data);
        end
      end
      if (e_lsb_done && !e_mem_we) begin
        checks++;
        if (lsb_rdata !== e_lsb_rdata) begin
          errors++; bad++; $display("FAIL rnd_lsb_rdata cyc %0d got %h exp %h", c, lsb_rdata, e_lsb_rdata);
        end
      end
      if (bad > 20) begin
        $display("FAIL rnd_abort too many differences got %0d exp 0", bad);
        break;
      end
    end
    spurious_en = 0;
  endtask

  initial begin
    rst = 1; ic_asking = 0; ic_addr = '0; ic_flush = 0;
    lsb_req = 0; lsb_we = 0; lsb_addr = '0; lsb_wdata = '0; lsb_wmask = '0;
    mem_rdata = '0; mem_ready = 0;
    n_mem_req = 0; n_ic_rdy = 0; n_lsb_done = 0;
    model_reset();
    test_reset();
    test_single_fetch();
    test_tie_init_prio();
    test_back_to_back();
    test_flush();
    test_drop_repeat();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
